// File: rtl/image_sram_loader_pkg.sv
// Shared types and constants for the image SRAM loader.
// Optional row parity output: LDR_ROW_PARITY_EN.
package img_ldr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    ROW,
    WAIT_NEXT,
    TERM
  } ldr_state_e;

  localparam logic [15:0] TERM_WORD = 16'h00FF;
  localparam logic [4:0]  DIM_10    = 5'd10;
  localparam logic [4:0]  DIM_12    = 5'd12;
  localparam logic [4:0]  DIM_16    = 5'd16;

  function automatic logic dim_legal(input logic [4:0] d);
    return (d == DIM_10) || (d == DIM_12) || (d == DIM_16);
  endfunction

endpackage

// File: rtl/image_sram_loader_if.sv
// Pixel stream handshake and SRAM write port of the loader.
// master = loader side, slave = pixel source / SRAM side.
interface image_sram_loader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              pix_valid;
  logic              pix_data;
  logic              pix_ready;
  logic [ADDR_W-1:0] ldr_sram_write_address;
  logic [DATA_W-1:0] ldr_sram_write_data;
  logic              ldr_sram_write_enable;

  modport master (
    input  pix_valid,
    input  pix_data,
    output pix_ready,
    output ldr_sram_write_address,
    output ldr_sram_write_data,
    output ldr_sram_write_enable
  );

  modport slave (
    output pix_valid,
    output pix_data,
    input  pix_ready,
    input  ldr_sram_write_address,
    input  ldr_sram_write_data,
    input  ldr_sram_write_enable
  );
endinterface

// File: rtl/image_sram_loader_row_packer.sv
// Packs a bit-serial row into one word, bit k of the row in word bit k.
// full is high for the single cycle in which the completed word is written.
module row_packer #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              en,
  input  logic [4:0]        dim,
  input  logic              pix_valid,
  input  logic              pix_data,
  output logic              pix_ready,
  output logic [DATA_W-1:0] word_nxt,
  output logic              last_bit,
  output logic              full
);
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [4:0]        col_q, col_d;
  logic              full_q, full_d;
  logic              xfer;

  assign full      = full_q;
  assign pix_ready = en & ~full_q;
  assign xfer      = pix_ready & pix_valid;
  assign last_bit  = xfer & (col_q == 5'(dim - 5'd1));
  assign word_nxt  = shift_q | (DATA_W'(pix_data) << col_q);

  always_comb begin
    shift_d = shift_q;
    col_d   = col_q;
    full_d  = 1'b0;
    if (!en) begin
      shift_d = '0;
      col_d   = '0;
    end else if (last_bit) begin
      // the word leaves via word_nxt, so the register restarts empty
      shift_d = '0;
      col_d   = '0;
      full_d  = 1'b1;
    end else if (xfer) begin
      shift_d = word_nxt;
      col_d   = col_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_b) begin
      shift_q <= '0;
      col_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      col_q   <= col_d;
      full_q  <= full_d;
    end
  end
endmodule

// File: rtl/image_sram_loader.sv
// Writes image records (header, N row words) and a terminator into SRAM.
// Optional ldr_parity output (XOR of rows) under LDR_ROW_PARITY_EN.
module image_sram_loader
  import img_ldr_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              ldr_start,
  input  logic [4:0]        ldr_dim,
  input  logic              ldr_last,
  image_sram_loader_if.master bus,
`ifdef LDR_ROW_PARITY_EN
  output logic [DATA_W-1:0] ldr_parity,
`endif
  output logic              ldr_busy,
  output logic              ldr_done,
  output logic              ldr_err
);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  ldr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [4:0]        dim_q, dim_d;
  logic              last_q, last_d;
  logic [4:0]        row_q, row_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef LDR_ROW_PARITY_EN
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] par_q, par_d;
`endif

  logic              pk_en;
  logic [DATA_W-1:0] word_nxt;
  logic              last_bit;
  logic              full;
  logic              last_row;

  assign pk_en    = (state_q == ROW);
  assign last_row = (row_q == 5'(dim_q - 5'd1));

  row_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk       (clk),
    .reset_b   (reset_b),
    .en        (pk_en),
    .dim       (dim_q),
    .pix_valid (bus.pix_valid),
    .pix_data  (bus.pix_data),
    .pix_ready (bus.pix_ready),
    .word_nxt  (word_nxt),
    .last_bit  (last_bit),
    .full      (full)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = we_q ? addr_q + 1'b1 : addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    dim_d   = dim_q;
    last_d  = last_q;
    row_d   = row_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
`ifdef LDR_ROW_PARITY_EN
    acc_d   = acc_q;
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE, WAIT_NEXT: begin
        if (ldr_start) begin
          if (dim_legal(ldr_dim)) begin
            state_d = HDR;
            we_d    = 1'b1;
            wdata_d = DATA_W'(ldr_dim);
            dim_d   = ldr_dim;
            last_d  = ldr_last;
            row_d   = '0;
            busy_d  = 1'b1;
`ifdef LDR_ROW_PARITY_EN
            acc_d   = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      HDR: state_d = ROW;
      ROW: begin
        if (last_bit) begin
          we_d    = 1'b1;
          wdata_d = word_nxt;
`ifdef LDR_ROW_PARITY_EN
          acc_d = acc_q ^ word_nxt;
          if (last_row) begin
            par_d = acc_q ^ word_nxt;
            acc_d = '0;
          end
`endif
        end
        // full marks the cycle the row word is on the bus
        if (full) begin
          if (last_row) begin
            row_d = '0;
            if (last_q) begin
              state_d = TERM;
              we_d    = 1'b1;
              wdata_d = DATA_W'(TERM_WORD);
            end else begin
              state_d = WAIT_NEXT;
            end
          end else begin
            row_d = row_q + 5'd1;
          end
        end
      end
      TERM: begin
        state_d = IDLE;
        addr_d  = BASE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_b) begin
      state_q <= IDLE;
      addr_q  <= BASE;
      wdata_q <= '0;
      we_q    <= 1'b0;
      dim_q   <= '0;
      last_q  <= 1'b0;
      row_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef LDR_ROW_PARITY_EN
      acc_q   <= '0;
      par_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      dim_q   <= dim_d;
      last_q  <= last_d;
      row_q   <= row_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef LDR_ROW_PARITY_EN
      acc_q   <= acc_d;
      par_q   <= par_d;
`endif
    end
  end

  assign bus.ldr_sram_write_address = addr_q;
  assign bus.ldr_sram_write_data    = wdata_q;
  assign bus.ldr_sram_write_enable  = we_q;
  assign ldr_busy = busy_q;
  assign ldr_done = done_q;
  assign ldr_err  = err_q;
`ifdef LDR_ROW_PARITY_EN
  assign ldr_parity = par_q;
`endif
endmodule

// File: doc/image_sram_loader.md
Name: image_sram_loader

Overview:
- Producer for the input SRAM of the binary 3x3 convolution engine. It writes the image records that the engine consumes.
- Accepts a bit-serial pixel stream over a valid/ready handshake and packs each image row into one 16-bit word.
- Writes one record per image: a dimension header word followed by N row words. After the last image it writes the terminator word 16'h00FF.
- Sits between the host/testbench pixel source and the input SRAM write port. It runs before the engine's dut_run is asserted.

Parameters:
- ADDR_W, 12, SRAM address width.
- DATA_W, 16, SRAM word width. It is also the maximum row width.
- BASE_ADDR, 0, address of the first header word.

Ports:
- clk  in  1  clock.
- reset_b  in  1  synchronous, active-high reset. The name is kept from the codebase; it is not active-low.
- ldr_start  in  1  one-cycle pulse that begins one image. Sampled only in IDLE or WAIT_NEXT.
- ldr_dim  in  5  image dimension N, sampled with ldr_start. Legal values: 10, 12, 16.
- ldr_last  in  1  sampled with ldr_start; 1 means this is the final image.
- pix_valid  in  1  pixel stream valid.
- pix_data  in  1  pixel bit.
- pix_ready  out  1  loader can accept a pixel.
- ldr_sram_write_address  out  ADDR_W  SRAM write address.
- ldr_sram_write_data  out  DATA_W  SRAM write data.
- ldr_sram_write_enable  out  1  SRAM write strobe.
- ldr_busy  out  1  high from accepted start until the terminator is written.
- ldr_done  out  1  one-cycle pulse after the terminator write.
- ldr_err  out  1  sticky: an illegal ldr_dim was presented. Cleared by reset.

Behaviour:
- Reset values: all outputs 0; ldr_sram_write_address = BASE_ADDR; state IDLE.
- States and transitions:
  - IDLE --ldr_start & legal dim--> HDR.
  - WAIT_NEXT --ldr_start & legal dim--> HDR.
  - HDR (1 cycle) --> ROW.
  - ROW --last row word written & !last_q--> WAIT_NEXT.
  - ROW --last row word written & last_q--> TERM.
  - TERM (1 cycle) --> IDLE, with ldr_done pulsed in the cycle after the TERM write.
- Illegal dim at start: set ldr_err, no write, state unchanged.
- HDR: write {11'd0, dim} at the current address; the address increments after the write.
- ROW handshake:
  - pix_ready = 1 only in ROW and only when the shift register is not holding a complete word.
  - A transfer occurs when pix_valid & pix_ready.
  - Bit k of a row (k = 0..N-1, in arrival order) lands in word bit k; bits N..15 are 0.
  - After N transfers, the word is written on the next cycle. pix_ready is 0 during that write cycle (one bubble per row).
  - Column and row counters clear after each word and after each image.
- Write timing: every write is registered. enable, address and data change together on the clock edge. Address increments by 1 after each write and wraps modulo 2^ADDR_W without a flag.
- Record layout per image: header at address A, rows at A+1..A+N. The next image header goes at A+N+1.
- TERM: write 16'h00FF at the current address. The address returns to BASE_ADDR on entry to IDLE.
- ldr_busy: set on an accepted start, cleared in the cycle ldr_done pulses. It stays high in WAIT_NEXT.
- ldr_start while in HDR/ROW/TERM is ignored.
- pix_valid outside ROW is ignored; no pixel is consumed.
- Reset mid-operation: abort immediately. No further writes; outputs return to reset values on the next edge.

Optional Feature:
- Macro LDR_ROW_PARITY_EN.
- With the macro:
  - Output ldr_parity[DATA_W-1:0] holds the XOR of all row words of the most recent completed image.
  - It updates in the cycle the last row word is written and resets to 0.
- Without the macro: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package img_ldr_pkg holds:
  - the state enum (IDLE, HDR, ROW, WAIT_NEXT, TERM);
  - constants TERM_WORD = 16'h00FF and DIM_10/12/16;
  - function dim_legal().
- One sub-module: row_packer. It contains the shift register, the column counter and word-complete detection, and produces the packed word plus a full flag.

Test Plan:
- Single 10x10 image of all-ones with ldr_last=1:
  - writes 0x000A at address 0 and 0x03FF at addresses 1..10;
  - writes 0x00FF at address 11;
  - ldr_done pulses once; ldr_busy falls.
- Two images, 12x12 then 16x16 with a checkerboard, pix_valid always high:
  - headers at address 0 (0x000C) and address 13 (0x0010);
  - rows alternate 0x0555/0x0AAA (12) and 0x5555/0xAAAA (16);
  - terminator at address 30.
- ldr_dim=11 at start: ldr_err=1, no write strobes, state stays IDLE. A following legal start proceeds normally.
- Random pix_valid gaps (about 50% duty) on a 10x10 image: memory contents match the gap-free run; pix_ready drops for exactly one cycle per row.
- reset_b asserted mid-row of the second image: no writes after the reset edge; address = BASE_ADDR, ldr_busy = 0; a fresh image then writes from address 0.
- With LDR_ROW_PARITY_EN, 10x10 image of rows 0x0001..0x000A: ldr_parity = 0x000B after the last row.
